// File: rtl/osd_menu_ctrl.sv
// osd_menu_ctrl: on-screen settings menu driven by a game-pad word stream.
// Holding L+R+Select+Start for HOLD_FRAMES frames opens a 4-row menu. The menu
// is drawn into a 16-cell text RAM (4 rows x 4 cols) and edits brightness,
// region and RGB select. It closes on B, Right/A on row 3, or after
// IDLE_FRAMES frames without a new press.
// Ports:
//   CLK_i, NRST_i            clock, async active-low reset
//   PAD_VALID_i, PAD_DATA_i  pad word strobe and word (1 = pressed)
//   VBLANK_i                 PPU vertical blank level (asynchronous)
//   OSD_EN_o                 menu visible
//   CURSOR_o                 selected row
//   BRIGHT_o/REGION_o/RGBSEL_o  persistent settings
//   CFG_CHANGED_o            one-cycle pulse after a setting change
//   TXT_WE_o/TXT_ADDR_o/TXT_DATA_o  text RAM write port
module osd_menu_ctrl #(
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned IDLE_FRAMES = 600
) (
    input  logic        CLK_i,
    input  logic        NRST_i,
    input  logic        PAD_VALID_i,
    input  logic [15:0] PAD_DATA_i,
    input  logic        VBLANK_i,
    output logic        OSD_EN_o,
    output logic [1:0]  CURSOR_o,
    output logic [3:0]  BRIGHT_o,
    output logic [1:0]  REGION_o,
    output logic        RGBSEL_o,
    output logic        CFG_CHANGED_o,
    output logic        TXT_WE_o,
    output logic [3:0]  TXT_ADDR_o,
    output logic [7:0]  TXT_DATA_o
);
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_FRAMES + 1);

    localparam int unsigned BTN_B      = 15;
    localparam int unsigned BTN_SELECT = 13;
    localparam int unsigned BTN_START  = 12;
    localparam int unsigned BTN_UP     = 11;
    localparam int unsigned BTN_DOWN   = 10;
    localparam int unsigned BTN_LEFT   = 9;
    localparam int unsigned BTN_RIGHT  = 8;
    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_L      = 5;
    localparam int unsigned BTN_R      = 4;

    typedef enum logic [2:0] {
        S_CLOSED,
        S_ARMING,
        S_RELEASE,
        S_REDRAW,
        S_OPEN
    } state_t;

    state_t              r_state;
    logic [2:0]          r_vb_sync;     // [0] stage 1, [1] stage 2, [2] stage 2 delayed
    logic [15:4]         r_prev;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [3:0]          r_cell;
    logic                r_osd_en;
    logic [1:0]          r_cursor;
    logic [3:0]          r_bright;
    logic [1:0]          r_region;
    logic                r_rgbsel;
    logic                r_cfg_chg;
    logic                r_txt_we;
    logic [3:0]          r_txt_addr;
    logic [7:0]          r_txt_data;

    logic                w_tick;
    logic [15:4]         w_new;
    logic                w_any_new;
    logic                w_combo;
    logic [1:0]          w_row;
    logic [7:0]          w_row_val;
    logic [7:0]          w_cell_data;
    logic                w_unused_pad;

    assign w_unused_pad = ^PAD_DATA_i[3:0];

    // Frame tick: rising edge of the second synchronizer stage
    assign w_tick    = r_vb_sync[1] & ~r_vb_sync[2];
    assign w_new     = PAD_DATA_i[15:4] & ~r_prev;
    assign w_any_new = PAD_VALID_i && (|w_new);
    assign w_combo   = PAD_DATA_i[BTN_L] & PAD_DATA_i[BTN_R] &
                       PAD_DATA_i[BTN_SELECT] & PAD_DATA_i[BTN_START];

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Character for the cell currently being drawn
    always_comb begin
        w_row       = r_cell[3:2];
        w_row_val   = 8'h00;
        w_cell_data = 8'h20;
        case (w_row)
            2'd0:    w_row_val = {4'h0, r_bright};
            2'd1:    w_row_val = {6'h00, r_region};
            2'd2:    w_row_val = {7'h00, r_rgbsel};
            default: w_row_val = 8'h00;
        endcase
        case (r_cell[1:0])
            2'd0:    w_cell_data = (r_cursor == w_row) ? 8'h3E : 8'h20;
            2'd1:    w_cell_data = 8'h3A;
            2'd2:    w_cell_data = hex_ascii(w_row_val[7:4]);
            default: w_cell_data = hex_ascii(w_row_val[3:0]);
        endcase
    end

    // Menu FSM with registered outputs
    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            r_state    <= S_CLOSED;
            r_vb_sync  <= '0;
            r_prev     <= '0;
            r_hold_cnt <= '0;
            r_idle_cnt <= '0;
            r_cell     <= '0;
            r_osd_en   <= 1'b0;
            r_cursor   <= 2'd0;
            r_bright   <= 4'd15;
            r_region   <= 2'd0;
            r_rgbsel   <= 1'b1;
            r_cfg_chg  <= 1'b0;
            r_txt_we   <= 1'b0;
            r_txt_addr <= 4'd0;
            r_txt_data <= 8'h00;
        end else begin
            r_vb_sync <= {r_vb_sync[1:0], VBLANK_i};
            r_cfg_chg <= 1'b0;
            r_txt_we  <= 1'b0;
            if (PAD_VALID_i) begin
                r_prev <= PAD_DATA_i[15:4];
            end

            case (r_state)
                S_CLOSED: begin
                    if (PAD_VALID_i && w_combo) begin
                        r_state    <= S_ARMING;
                        r_hold_cnt <= '0;
                    end
                end

                S_ARMING: begin
                    if (PAD_VALID_i && !w_combo) begin
                        r_state <= S_CLOSED;
                    end else if (w_tick) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        if (r_hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                            r_osd_en <= 1'b1;
                            r_state  <= S_RELEASE;
                        end
                    end
                end

                S_RELEASE: begin
                    if (PAD_VALID_i && (PAD_DATA_i[15:4] == 12'h000)) begin
                        r_state <= S_REDRAW;
                        r_cell  <= 4'd0;
                    end
                end

                // One cell per cycle; the write port lags r_cell by one cycle
                S_REDRAW: begin
                    r_txt_we   <= 1'b1;
                    r_txt_addr <= r_cell;
                    r_txt_data <= w_cell_data;
                    r_cell     <= r_cell + 4'd1;
                    if (r_cell == 4'd15) begin
                        r_state    <= S_OPEN;
                        r_idle_cnt <= '0;
                    end
                end

                S_OPEN: begin
                    if (w_any_new) begin
                        // A new press always wins over idle expiry
                        r_idle_cnt <= '0;
                        r_cell     <= 4'd0;
                        if (w_new[BTN_B]) begin
                            r_osd_en <= 1'b0;
                            r_state  <= S_CLOSED;
                        end else if (w_new[BTN_UP]) begin
                            r_cursor <= r_cursor - 2'd1;
                            r_state  <= S_REDRAW;
                        end else if (w_new[BTN_DOWN]) begin
                            r_cursor <= r_cursor + 2'd1;
                            r_state  <= S_REDRAW;
                        end else if (w_new[BTN_LEFT]) begin
                            case (r_cursor)
                                2'd0: begin
                                    if (r_bright != 4'd0) begin
                                        r_bright  <= r_bright - 4'd1;
                                        r_cfg_chg <= 1'b1;
                                        r_state   <= S_REDRAW;
                                    end
                                end
                                2'd1: begin
                                    r_region  <= (r_region == 2'd0) ? 2'd2 : r_region - 2'd1;
                                    r_cfg_chg <= 1'b1;
                                    r_state   <= S_REDRAW;
                                end
                                2'd2: begin
                                    r_rgbsel  <= ~r_rgbsel;
                                    r_cfg_chg <= 1'b1;
                                    r_state   <= S_REDRAW;
                                end
                                default: ;
                            endcase
                        end else if (w_new[BTN_RIGHT]) begin
                            case (r_cursor)
                                2'd0: begin
                                    if (r_bright != 4'd15) begin
                                        r_bright  <= r_bright + 4'd1;
                                        r_cfg_chg <= 1'b1;
                                        r_state   <= S_REDRAW;
                                    end
                                end
                                2'd1: begin
                                    r_region  <= (r_region >= 2'd2) ? 2'd0 : r_region + 2'd1;
                                    r_cfg_chg <= 1'b1;
                                    r_state   <= S_REDRAW;
                                end
                                2'd2: begin
                                    r_rgbsel  <= ~r_rgbsel;
                                    r_cfg_chg <= 1'b1;
                                    r_state   <= S_REDRAW;
                                end
                                default: begin
                                    r_osd_en <= 1'b0;
                                    r_state  <= S_CLOSED;
                                end
                            endcase
                        end else if (w_new[BTN_A]) begin
                            if (r_cursor == 2'd3) begin
                                r_osd_en <= 1'b0;
                                r_state  <= S_CLOSED;
                            end
                        end
                    end else if (w_tick) begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        if (r_idle_cnt == IDLE_W'(IDLE_FRAMES - 1)) begin
                            r_osd_en <= 1'b0;
                            r_state  <= S_CLOSED;
                        end
                    end
                end

                default: r_state <= S_CLOSED;
            endcase
        end
    end

    assign OSD_EN_o      = r_osd_en;
    assign CURSOR_o      = r_cursor;
    assign BRIGHT_o      = r_bright;
    assign REGION_o      = r_region;
    assign RGBSEL_o      = r_rgbsel;
    assign CFG_CHANGED_o = r_cfg_chg;
    assign TXT_WE_o      = r_txt_we;
    assign TXT_ADDR_o    = r_txt_addr;
    assign TXT_DATA_o    = r_txt_data;

endmodule

// File: tb/tb_osd_menu_ctrl.sv
// tb_osd_menu_ctrl: self-checking bench for osd_menu_ctrl. A behavioural model
// of the menu settings and text layout predicts outputs, write counts and
// CFG_CHANGED pulses for directed scenarios and randomized pad presses.
module tb_osd_menu_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pad_valid = 1'b0;
    logic [15:0] pad_data = 16'h0000;
    logic        vblank = 1'b0;
    logic        osd_en;
    logic [1:0]  cursor;
    logic [3:0]  bright;
    logic [1:0]  region;
    logic        rgbsel;
    logic        cfg_chg;
    logic        txt_we;
    logic [3:0]  txt_addr;
    logic [7:0]  txt_data;

    osd_menu_ctrl #(.HOLD_FRAMES(60), .IDLE_FRAMES(600)) dut (
        .CLK_i         (clk),
        .NRST_i        (nrst),
        .PAD_VALID_i   (pad_valid),
        .PAD_DATA_i    (pad_data),
        .VBLANK_i      (vblank),
        .OSD_EN_o      (osd_en),
        .CURSOR_o      (cursor),
        .BRIGHT_o      (bright),
        .REGION_o      (region),
        .RGBSEL_o      (rgbsel),
        .CFG_CHANGED_o (cfg_chg),
        .TXT_WE_o      (txt_we),
        .TXT_ADDR_o    (txt_addr),
        .TXT_DATA_o    (txt_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Text RAM image, write/pulse counters and address-order tracking
    logic [7:0] cap [16];
    int         wr_cnt   = 0;
    int         cfg_cnt  = 0;
    int         addr_err = 0;
    logic       prev_we  = 1'b0;
    logic [3:0] next_addr = 4'd0;

    always @(posedge clk) begin
        if (txt_we) begin
            if (txt_addr != (prev_we ? next_addr : 4'd0)) addr_err <= addr_err + 1;
            next_addr     <= (prev_we ? next_addr : 4'd0) + 4'd1;
            cap[txt_addr] <= txt_data;
            wr_cnt        <= wr_cnt + 1;
        end
        prev_we <= txt_we;
        if (cfg_chg) cfg_cnt <= cfg_cnt + 1;
    end

    // Reference model
    int          m_bright, m_region, m_rgb, m_cursor;
    bit          m_open;
    logic [15:0] m_prev;

    task automatic model_reset();
        m_bright = 15; m_region = 0; m_rgb = 1; m_cursor = 0;
        m_open = 1'b0; m_prev = 16'h0000;
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic logic [7:0] exp_cell(input int a);
        int row, col, val;
        row = a / 4;
        col = a % 4;
        case (row)
            0: val = m_bright;
            1: val = m_region;
            2: val = m_rgb;
            default: val = 0;
        endcase
        case (col)
            0: return (m_cursor == row) ? 8'h3E : 8'h20;
            1: return 8'h3A;
            2: return hexc(val / 16);
            default: return hexc(val % 16);
        endcase
    endfunction

    task automatic model_press(input logic [15:0] d, output bit chg, output bit rd);
        logic [15:0] np;
        np = d & ~m_prev;
        m_prev = d;
        chg = 1'b0;
        rd  = 1'b0;
        if (np[15]) m_open = 1'b0;
        else if (np[11]) begin m_cursor = (m_cursor + 3) % 4; rd = 1'b1; end
        else if (np[10]) begin m_cursor = (m_cursor + 1) % 4; rd = 1'b1; end
        else if (np[9]) begin
            case (m_cursor)
                0: if (m_bright > 0) begin m_bright = m_bright - 1; chg = 1'b1; end
                1: begin m_region = (m_region + 2) % 3; chg = 1'b1; end
                2: begin m_rgb = 1 - m_rgb; chg = 1'b1; end
                default: ;
            endcase
            rd = chg;
        end else if (np[8]) begin
            case (m_cursor)
                0: if (m_bright < 15) begin m_bright = m_bright + 1; chg = 1'b1; end
                1: begin m_region = (m_region + 1) % 3; chg = 1'b1; end
                2: begin m_rgb = 1 - m_rgb; chg = 1'b1; end
                default: m_open = 1'b0;
            endcase
            rd = chg;
        end else if (np[7]) begin
            if (m_cursor == 3) m_open = 1'b0;
        end
    endtask

    // Stimulus helpers
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pad(input logic [15:0] d);
        @(negedge clk);
        pad_valid = 1'b1;
        pad_data  = d;
        @(negedge clk);
        pad_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        vblank = 1'b1;
        cyc(4);
        vblank = 1'b0;
        cyc(3);
    endtask

    // Pad strobe lands in the same cycle as the frame tick
    task automatic tick_with_press(input logic [15:0] d);
        @(negedge clk);
        vblank = 1'b1;
        cyc(2);
        pad_valid = 1'b1;
        pad_data  = d;
        @(negedge clk);
        pad_valid = 1'b0;
        cyc(2);
        vblank = 1'b0;
        cyc(3);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_osd"},    32'(osd_en), 32'(m_open));
        chk({tag, "_cursor"}, 32'(cursor), 32'(m_cursor));
        chk({tag, "_bright"}, 32'(bright), 32'(m_bright));
        chk({tag, "_region"}, 32'(region), 32'(m_region));
        chk({tag, "_rgb"},    32'(rgbsel), 32'(m_rgb));
    endtask

    task automatic check_cells(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_cell%0d", tag, i), 32'(cap[i]), 32'(exp_cell(i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_osd"},    32'(osd_en),   0);
        chk({tag, "_cursor"}, 32'(cursor),   0);
        chk({tag, "_bright"}, 32'(bright),   15);
        chk({tag, "_region"}, 32'(region),   0);
        chk({tag, "_rgb"},    32'(rgbsel),   1);
        chk({tag, "_cfg"},    32'(cfg_chg),  0);
        chk({tag, "_we"},     32'(txt_we),   0);
        chk({tag, "_addr"},   32'(txt_addr), 0);
        chk({tag, "_data"},   32'(txt_data), 0);
    endtask

    task automatic open_menu(input string tag);
        int w0;
        w0 = wr_cnt;
        pad(16'h3030);
        m_prev = 16'h3030;
        repeat (59) tick();
        chk({tag, "_hold59"}, 32'(osd_en), 0);
        tick();
        chk({tag, "_hold60"}, 32'(osd_en), 1);
        pad(16'h1000);
        cyc(24);
        chk({tag, "_held_nowr"}, 32'(wr_cnt - w0), 0);
        pad(16'h000F);
        m_prev = 16'h0000;
        cyc(24);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 16);
        m_open = 1'b1;
        check_state(tag);
        check_cells(tag);
    endtask

    task automatic press(input logic [15:0] d, input string tag);
        int w0, c0;
        bit chg, rd;
        w0 = wr_cnt;
        c0 = cfg_cnt;
        model_press(d, chg, rd);
        pad(d);
        cyc(24);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), rd ? 32'd16 : 32'd0);
        chk({tag, "_cfg"},    32'(cfg_cnt - c0), chg ? 32'd1 : 32'd0);
        check_state(tag);
        if (rd) check_cells(tag);
        pad(16'h0000);
        m_prev = 16'h0000;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0;
        logic [15:0] d;
        bit          chg, rd;

        model_reset();
        cyc(3);
        check_reset_outputs("rst");
        nrst = 1'b1;
        cyc(3);

        // Combo released after 30 ticks
        w0 = wr_cnt;
        pad(16'h3030);
        repeat (30) tick();
        pad(16'h3020);
        repeat (40) tick();
        chk("abort_osd", 32'(osd_en), 0);
        chk("abort_writes", 32'(wr_cnt - w0), 0);
        pad(16'h0000);

        // Open, saturation, single step
        open_menu("open1");
        press(16'h0100, "right_sat");
        press(16'h0200, "left");
        chk("left_cell3", 32'(cap[3]), 32'h45);

        // Cursor wrap and close by A on row 3, then reopen
        press(16'h0800, "up_wrap");
        press(16'h0080, "a_row3");
        chk("a_row3_closed", 32'(osd_en), 0);
        open_menu("reopen");

        // Region cycling on row 1
        press(16'h0400, "down0");
        press(16'h0400, "down1");
        press(16'h0200, "reg_left");
        press(16'h0100, "reg_right1");
        press(16'h0100, "reg_right2");
        chk("region_final", 32'(region), 1);

        // Idle timeout
        repeat (599) tick();
        chk("idle599_open", 32'(osd_en), 1);
        tick();
        m_open = 1'b0;
        chk("idle600_closed", 32'(osd_en), 0);

        // New press on the expiry tick keeps the menu open and restarts idle
        open_menu("idle_re");
        repeat (599) tick();
        model_press(16'h0040, chg, rd);
        tick_with_press(16'h0040);
        chk("press_on_expiry_open", 32'(osd_en), 1);
        pad(16'h0000);
        m_prev = 16'h0000;
        repeat (599) tick();
        chk("idle_restart599", 32'(osd_en), 1);
        tick();
        m_open = 1'b0;
        chk("idle_restart600", 32'(osd_en), 0);

        // Randomized presses
        for (int k = 0; k < 40; k++) begin
            if (!m_open) open_menu($sformatf("ropen%0d", k));
            case ($urandom_range(0, 7))
                0: d = 16'h0800;
                1: d = 16'h0400;
                2: d = 16'h0200;
                3: d = 16'h0100;
                4: d = 16'h0080;
                5: d = 16'h0040;
                default: begin
                    d = 16'($urandom) & 16'h7FF0;
                    if ($urandom_range(0, 15) == 0) d[15] = 1'b1;
                end
            endcase
            press(d, $sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of a redraw
        if (!m_open) open_menu("pre_rst");
        model_press(16'h0400, chg, rd);
        pad(16'h0400);
        cyc(4);
        chk("mid_redraw_we", 32'(txt_we), 1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        cyc(3);
        nrst = 1'b1;
        cyc(3);
        open_menu("post_rst");

        chk("addr_seq", 32'(addr_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
